// File: rtl/csi2_packet_parser_if.sv
// Byte stream from the D-PHY receiver plus the decoded header, payload
// and status signals of the CSI-2 packet parser.
interface csi2_packet_parser_if;
  logic [7:0]  phy_data;
  logic        phy_enable;
  logic        phy_reset;
  logic        header_valid;
  logic [1:0]  virtual_channel;
  logic [5:0]  data_type;
  logic [15:0] word_count;
  logic        ecc_error;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        packet_done;
  logic        crc_error;

  // master: the byte source and result consumer; slave: the parser
  modport master (
    output phy_data, phy_enable,
    input  phy_reset, header_valid, virtual_channel, data_type, word_count,
           ecc_error, payload_data, payload_valid, packet_done, crc_error
  );

  modport slave (
    input  phy_data, phy_enable,
    output phy_reset, header_valid, virtual_channel, data_type, word_count,
           ecc_error, payload_data, payload_valid, packet_done, crc_error
  );
endinterface

// File: rtl/csi2_packet_parser.sv
// Single-lane CSI-2 packet parser: header decode with ECC check, payload
// forwarding with CRC-16 check, and a PHY reset pulse at packet end.
module csi2_packet_parser #(
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input logic            clock_p,
  input logic            reset,
  csi2_packet_parser_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_PAYLOAD,
    ST_CRC,
    ST_END
  } state_t;

  // Each parity bit covers a fixed subset of header bits D0..D23.
  function automatic logic [5:0] ecc_calc(input logic [23:0] d);
    ecc_calc[0] = ^(d & 24'hF12CB7);
    ecc_calc[1] = ^(d & 24'hF2555B);
    ecc_calc[2] = ^(d & 24'h749A6D);
    ecc_calc[3] = ^(d & 24'hB8E38E);
    ecc_calc[4] = ^(d & 24'hDF03F0);
    ecc_calc[5] = ^(d & 24'hEFFC00);
  endfunction

  // Reflected CRC-16 (0x8408), one byte processed LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] hdr_q, hdr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_lo_q, crc_lo_d;

  logic        header_valid_q, header_valid_d;
  logic [1:0]  virtual_channel_q, virtual_channel_d;
  logic [5:0]  data_type_q, data_type_d;
  logic [15:0] word_count_q, word_count_d;
  logic        ecc_error_q, ecc_error_d;
  logic [7:0]  payload_data_q, payload_data_d;
  logic        payload_valid_q, payload_valid_d;
  logic        packet_done_q, packet_done_d;
  logic        phy_reset_q, phy_reset_d;
  logic        crc_error_q, crc_error_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d           = state_q;
    byte_cnt_d        = byte_cnt_q;
    hdr_d             = hdr_q;
    remaining_d       = remaining_q;
    crc_d             = crc_q;
    crc_lo_d          = crc_lo_q;
    virtual_channel_d = virtual_channel_q;
    data_type_d       = data_type_q;
    word_count_d      = word_count_q;
    ecc_error_d       = ecc_error_q;
    payload_data_d    = payload_data_q;
    crc_error_d       = crc_error_q;
    header_valid_d    = 1'b0;
    payload_valid_d   = 1'b0;

    case (state_q)
      ST_HEADER: begin
        if (bus.phy_enable) begin
          if (byte_cnt_q != 2'd3) begin
            hdr_d[{byte_cnt_q, 3'b000} +: 8] = bus.phy_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end else begin
            header_valid_d    = 1'b1;
            virtual_channel_d = hdr_q[7:6];
            data_type_d       = hdr_q[5:0];
            word_count_d      = hdr_q[23:8];
            ecc_error_d       = (bus.phy_data != {2'b00, ecc_calc(hdr_q)});
            byte_cnt_d        = 2'd0;
            remaining_d       = hdr_q[23:8];
            // A corrupted header is still acted on; there is no correction.
            if (hdr_q[5:0] <= SHORT_DT_MAX) begin
              state_d     = ST_END;
              crc_error_d = 1'b0;
            end else if (hdr_q[23:8] == 16'd0) begin
              state_d = ST_CRC;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (bus.phy_enable) begin
          payload_valid_d = 1'b1;
          payload_data_d  = bus.phy_data;
          crc_d           = crc_step(crc_q, bus.phy_data);
          remaining_d     = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = ST_CRC;
        end
      end

      ST_CRC: begin
        if (bus.phy_enable) begin
          if (byte_cnt_q == 2'd0) begin
            crc_lo_d   = bus.phy_data;
            byte_cnt_d = 2'd1;
          end else begin
            crc_error_d = ({bus.phy_data, crc_lo_q} != crc_q);
            byte_cnt_d  = 2'd0;
            state_d     = ST_END;
          end
        end
      end

      ST_END: begin
        state_d     = ST_HEADER;
        byte_cnt_d  = 2'd0;
        remaining_d = 16'd0;
        crc_d       = 16'hFFFF;
      end

      default: state_d = ST_HEADER;
    endcase

    // END lasts exactly one cycle, so registering entry into it gives the pulse.
    packet_done_d = (state_d == ST_END);
    phy_reset_d   = (state_d == ST_END);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before this clock edge.
  always_ff @(posedge clock_p) begin
    if (reset) begin
      state_q           <= ST_HEADER;
      byte_cnt_q        <= 2'd0;
      hdr_q             <= 24'd0;
      remaining_q       <= 16'd0;
      crc_q             <= 16'hFFFF;
      crc_lo_q          <= 8'd0;
      header_valid_q    <= 1'b0;
      virtual_channel_q <= 2'd0;
      data_type_q       <= 6'd0;
      word_count_q      <= 16'd0;
      ecc_error_q       <= 1'b0;
      payload_data_q    <= 8'd0;
      payload_valid_q   <= 1'b0;
      packet_done_q     <= 1'b0;
      phy_reset_q       <= 1'b0;
      crc_error_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      byte_cnt_q        <= byte_cnt_d;
      hdr_q             <= hdr_d;
      remaining_q       <= remaining_d;
      crc_q             <= crc_d;
      crc_lo_q          <= crc_lo_d;
      header_valid_q    <= header_valid_d;
      virtual_channel_q <= virtual_channel_d;
      data_type_q       <= data_type_d;
      word_count_q      <= word_count_d;
      ecc_error_q       <= ecc_error_d;
      payload_data_q    <= payload_data_d;
      payload_valid_q   <= payload_valid_d;
      packet_done_q     <= packet_done_d;
      phy_reset_q       <= phy_reset_d;
      crc_error_q       <= crc_error_d;
    end
  end

  assign bus.header_valid    = header_valid_q;
  assign bus.virtual_channel = virtual_channel_q;
  assign bus.data_type       = data_type_q;
  assign bus.word_count      = word_count_q;
  assign bus.ecc_error       = ecc_error_q;
  assign bus.payload_data    = payload_data_q;
  assign bus.payload_valid   = payload_valid_q;
  assign bus.packet_done     = packet_done_q;
  assign bus.phy_reset       = phy_reset_q;
  assign bus.crc_error       = crc_error_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Directed bench for csi2_packet_parser: short/long packets, ECC and CRC
// errors, gapped enables and reset in the middle of a packet.
module tb_csi2_packet_parser;

  logic clock_p = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  csi2_packet_parser_if bus ();

  csi2_packet_parser #(.SHORT_DT_MAX(6'h0F)) dut (
    .clock_p (clock_p),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock_p = ~clock_p;
  always @(posedge clock_p) cyc <= cyc + 1;

  // Event log filled on the falling edge, away from the sampling edge.
  logic [7:0]  pv_data [$];
  int          pv_cyc  [$];
  int          hv_count = 0, hv_cyc = 0;
  logic [1:0]  hv_vc;
  logic [5:0]  hv_dt;
  logic [15:0] hv_wc;
  logic        hv_ecc;
  int          pd_count = 0, pd_cyc = 0, pr_count = 0;
  logic        pd_crc;

  always @(negedge clock_p) begin
    if (bus.payload_valid) begin
      pv_data.push_back(bus.payload_data);
      pv_cyc.push_back(cyc);
    end
    if (bus.header_valid) begin
      hv_count++;
      hv_cyc = cyc;
      hv_vc  = bus.virtual_channel;
      hv_dt  = bus.data_type;
      hv_wc  = bus.word_count;
      hv_ecc = bus.ecc_error;
    end
    if (bus.packet_done) begin
      pd_count++;
      pd_cyc = cyc;
      pd_crc = bus.crc_error;
    end
    if (bus.phy_reset) pr_count++;
  end

  // ECC reference: XOR of the syndrome of every set header bit.
  function automatic logic [5:0] syndrome(input int i);
    case (i)
      0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
      4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
      8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
     12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
     16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
     20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; 23: return 6'h3B;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [7:0] ecc_model(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  p;
    d = {wc, di};
    p = 6'h00;
    for (int i = 0; i < 24; i++) if (d[i]) p = p ^ syndrome(i);
    return {2'b00, p};
  endfunction

  logic [7:0] pkt_buf [0:15];
  int         pkt_len;
  int         acc_cyc [0:15];

  task automatic send_packet(input bit gapped);
    for (int i = 0; i < pkt_len; i++) begin
      if (gapped) begin
        for (int g = 0; g < 8 && $urandom_range(0, 3) != 0; g++) begin
          @(negedge clock_p);
          bus.phy_enable = 1'b0;
          bus.phy_data   = 8'($urandom);
        end
      end
      @(negedge clock_p);
      bus.phy_enable = 1'b1;
      bus.phy_data   = pkt_buf[i];
      acc_cyc[i]     = cyc;
    end
    @(negedge clock_p);
    bus.phy_enable = 1'b0;
    bus.phy_data   = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_p);
    #1;
  endtask

  task automatic set_header(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
    pkt_buf[0] = di;
    pkt_buf[1] = wc[7:0];
    pkt_buf[2] = wc[15:8];
    pkt_buf[3] = ecc;
  endtask

  task automatic test_reset();
    @(negedge clock_p);
    reset          = 1'b1;
    bus.phy_enable = 1'b1;
    bus.phy_data   = 8'hA5;
    idle(3);
    n_checks++;
    if ({bus.header_valid, bus.payload_valid, bus.packet_done, bus.phy_reset} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {bus.header_valid, bus.payload_valid, bus.packet_done, bus.phy_reset});
    end
    n_checks++;
    if ({bus.virtual_channel, bus.data_type, bus.word_count} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h expected 000000",
               {bus.virtual_channel, bus.data_type, bus.word_count});
    end
    n_checks++;
    if ({bus.ecc_error, bus.crc_error, bus.payload_data} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_status: got %h expected 000",
               {bus.ecc_error, bus.crc_error, bus.payload_data});
    end
    @(negedge clock_p);
    reset          = 1'b0;
    bus.phy_enable = 1'b0;
    bus.phy_data   = 8'h00;
    idle(2);
  endtask

  task automatic test_short(input string name, input logic [7:0] di, input logic [15:0] wc,
                            input logic [7:0] ecc, input bit exp_ecc_err);
    int pv0, hv0, pd0, pr0;
    pv0 = pv_data.size(); hv0 = hv_count; pd0 = pd_count; pr0 = pr_count;
    set_header(di, wc, ecc);
    pkt_len = 4;
    send_packet(1'b0);
    idle(4);
    n_checks++;
    if (hv_count - hv0 !== 1) begin
      n_fail++; $display("FAIL %s header_valid count: got %0d expected 1", name, hv_count - hv0);
    end
    n_checks++;
    if ({hv_vc, hv_dt, hv_wc} !== {di, wc}) begin
      n_fail++; $display("FAIL %s fields: got %h expected %h", name, {hv_vc, hv_dt, hv_wc}, {di, wc});
    end
    n_checks++;
    if (hv_ecc !== exp_ecc_err) begin
      n_fail++; $display("FAIL %s ecc_error: got %b expected %b", name, hv_ecc, exp_ecc_err);
    end
    n_checks++;
    if (hv_cyc !== acc_cyc[3] + 1) begin
      n_fail++; $display("FAIL %s header latency: got cycle %0d expected %0d", name, hv_cyc, acc_cyc[3] + 1);
    end
    n_checks++;
    if (pd_count - pd0 !== 1 || pr_count - pr0 !== 1) begin
      n_fail++; $display("FAIL %s done/phy_reset pulses: got %0d/%0d expected 1/1",
                         name, pd_count - pd0, pr_count - pr0);
    end
    n_checks++;
    if (pd_crc !== 1'b0) begin
      n_fail++; $display("FAIL %s crc_error: got %b expected 0", name, pd_crc);
    end
    n_checks++;
    if (pv_data.size() - pv0 !== 0) begin
      n_fail++; $display("FAIL %s payload_valid count: got %0d expected 0", name, pv_data.size() - pv0);
    end
    n_checks++;
    if (bus.word_count !== wc || bus.data_type !== di[5:0]) begin
      n_fail++; $display("FAIL %s field hold: got %h/%h expected %h/%h",
                         name, bus.word_count, bus.data_type, wc, di[5:0]);
    end
  endtask

  task automatic test_long(input string name, input logic [7:0] crc_lo, input logic [7:0] crc_hi,
                           input bit exp_err, input bit gapped);
    int pv0, pd0;
    logic [7:0] exp_b;
    pv0 = pv_data.size(); pd0 = pd_count;
    set_header(8'h2A, 16'h0009, ecc_model(8'h2A, 16'h0009));
    for (int i = 0; i < 9; i++) pkt_buf[4 + i] = 8'h31 + 8'(i);
    pkt_buf[13] = crc_lo;
    pkt_buf[14] = crc_hi;
    pkt_len = 15;
    send_packet(gapped);
    idle(4);
    n_checks++;
    if ({hv_vc, hv_dt, hv_wc, hv_ecc} !== {2'd0, 6'h2A, 16'h0009, 1'b0}) begin
      n_fail++; $display("FAIL %s header: got %h expected %h", name,
                         {hv_vc, hv_dt, hv_wc, hv_ecc}, {2'd0, 6'h2A, 16'h0009, 1'b0});
    end
    n_checks++;
    if (pv_data.size() - pv0 !== 9) begin
      n_fail++; $display("FAIL %s payload count: got %0d expected 9", name, pv_data.size() - pv0);
    end
    for (int i = 0; i < 9 && pv0 + i < pv_data.size(); i++) begin
      exp_b = 8'h31 + 8'(i);
      n_checks++;
      if (pv_data[pv0 + i] !== exp_b || pv_cyc[pv0 + i] !== acc_cyc[4 + i] + 1) begin
        n_fail++; $display("FAIL %s payload[%0d]: got %h at cycle %0d expected %h at cycle %0d",
                           name, i, pv_data[pv0 + i], pv_cyc[pv0 + i], exp_b, acc_cyc[4 + i] + 1);
      end
    end
    n_checks++;
    if (pd_count - pd0 !== 1 || pd_cyc !== acc_cyc[14] + 1) begin
      n_fail++; $display("FAIL %s packet_done: got %0d pulses at cycle %0d expected 1 at cycle %0d",
                         name, pd_count - pd0, pd_cyc, acc_cyc[14] + 1);
    end
    n_checks++;
    if (pd_crc !== exp_err) begin
      n_fail++; $display("FAIL %s crc_error: got %b expected %b", name, pd_crc, exp_err);
    end
    n_checks++;
    if (bus.crc_error !== exp_err) begin
      n_fail++; $display("FAIL %s crc_error hold: got %b expected %b", name, bus.crc_error, exp_err);
    end
  endtask

  task automatic test_long_wc0(input string name, input bit gapped);
    int pv0, pd0;
    pv0 = pv_data.size(); pd0 = pd_count;
    set_header(8'h2A, 16'h0000, ecc_model(8'h2A, 16'h0000));
    pkt_buf[4] = 8'hFF;
    pkt_buf[5] = 8'hFF;
    pkt_len = 6;
    send_packet(gapped);
    idle(4);
    n_checks++;
    if ({hv_dt, hv_wc, hv_ecc} !== {6'h2A, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL %s header: got %h expected %h", name, {hv_dt, hv_wc, hv_ecc}, {6'h2A, 17'h0});
    end
    n_checks++;
    if (pv_data.size() - pv0 !== 0) begin
      n_fail++; $display("FAIL %s payload count: got %0d expected 0", name, pv_data.size() - pv0);
    end
    n_checks++;
    if (pd_count - pd0 !== 1 || pd_crc !== 1'b0) begin
      n_fail++; $display("FAIL %s done/crc_error: got %0d/%b expected 1/0", name, pd_count - pd0, pd_crc);
    end
  endtask

  task automatic test_abort();
    int pv0, pd0, pr0;
    pv0 = pv_data.size(); pd0 = pd_count; pr0 = pr_count;
    set_header(8'h2A, 16'h0009, ecc_model(8'h2A, 16'h0009));
    for (int i = 0; i < 3; i++) pkt_buf[4 + i] = 8'h31 + 8'(i);
    pkt_len = 7;
    send_packet(1'b0);
    reset = 1'b1;
    @(negedge clock_p);
    reset = 1'b0;
    idle(4);
    n_checks++;
    if (pv_data.size() - pv0 !== 3) begin
      n_fail++; $display("FAIL abort payload count: got %0d expected 3", pv_data.size() - pv0);
    end
    n_checks++;
    if (pd_count - pd0 !== 0 || pr_count - pr0 !== 0) begin
      n_fail++; $display("FAIL abort pulses: got done %0d phy_reset %0d expected 0/0",
                         pd_count - pd0, pr_count - pr0);
    end
    test_short("after_abort", 8'h45, 16'h1234, ecc_model(8'h45, 16'h1234), 1'b0);
  endtask

  initial begin
    bus.phy_enable = 1'b0;
    bus.phy_data   = 8'h00;
    test_reset();
    test_short("short_zero", 8'h00, 16'h0000, 8'h00, 1'b0);
    test_short("short_ecc_bad", 8'h00, 16'h0000, 8'h01, 1'b1);
    test_short("short_fields", 8'h45, 16'h1234, ecc_model(8'h45, 16'h1234), 1'b0);
    test_short("short_ecc_hi", 8'hC3, 16'hBEEF, ecc_model(8'hC3, 16'hBEEF) | 8'h40, 1'b1);
    test_long("long_good", 8'h91, 8'h6F, 1'b0, 1'b0);
    test_long("long_bad", 8'h92, 8'h6F, 1'b1, 1'b0);
    test_long_wc0("long_wc0", 1'b0);
    test_long("long_good_gapped", 8'h91, 8'h6F, 1'b0, 1'b1);
    test_long_wc0("long_wc0_gapped", 1'b1);
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csi2_packet_parser.md
Name: csi2_packet_parser

Overview:
Single-lane CSI-2 low-level protocol parser. It sits directly downstream of the HS-only D-PHY byte receiver and consumes its byte/enable stream on the same clock. Each packet's 4-byte header is decoded into virtual channel, data type and word count, and the ECC is checked. Long-packet payload bytes are forwarded, the payload CRC-16 is checked, and a one-cycle reset is issued back to the PHY at packet end, because the PHY cannot detect LP return on its own.

Parameters:
SHORT_DT_MAX, 6'h0F, highest data type treated as a short packet (0x00..SHORT_DT_MAX short; others long)

Ports:
clock_p  input  1  D-PHY HS byte-domain clock
reset  input  1  synchronous, active-high
phy_data  input  8  byte from D-PHY receiver
phy_enable  input  1  phy_data valid this cycle
phy_reset  output  1  one-cycle pulse to D-PHY receiver reset at packet end
header_valid  output  1  one-cycle pulse: header fields updated
virtual_channel  output  2  DI[7:6]
data_type  output  6  DI[5:0]
word_count  output  16  WC (short packet: data field); {byte2,byte1}
ecc_error  output  1  valid with header_valid; received ECC != computed
payload_data  output  8  long-packet payload byte
payload_valid  output  1  payload_data valid
packet_done  output  1  one-cycle pulse at end of packet
crc_error  output  1  valid with packet_done; long packets only, 0 for short

Behaviour:
- Reset: all outputs 0, state HEADER, byte count 0, CRC register 16'hFFFF. Reset dominates all other inputs in the same cycle.
- Bytes are accepted only in cycles with phy_enable=1; other cycles hold state.
- States: HEADER, PAYLOAD, CRC, END.
- HEADER: collect 4 bytes (DI, WC_LSB, WC_MSB, ECC).
  - On the 4th byte, the next cycle pulses header_valid with virtual_channel, data_type, word_count and ecc_error.
  - ECC is the CSI-2 6-bit Hamming code over header bits D0..D23. Compare the received byte as {2'b00, P5..P0}; nonzero bits 7:6 also flag ecc_error. No correction is performed.
  - Next state: short DT -> END; long DT with WC=0 -> CRC; otherwise -> PAYLOAD.
  - A header with ecc_error is still acted on.
- PAYLOAD: each accepted byte appears on payload_data with payload_valid=1 the following cycle (latency 1).
  - The CRC register is updated and the remaining-byte counter decrements.
  - After WC bytes -> CRC.
- CRC: CRC-16, poly x^16+x^12+x^5+1, reflected (0x8408), init 16'hFFFF, LSB-first, no final XOR.
  - Collect 2 bytes, LSB first.
  - On the 2nd byte -> END; crc_error = (received != computed).
- END: for exactly one cycle, phy_reset=1, packet_done=1 and crc_error is valid. Then return to HEADER with counters cleared and CRC set to 16'hFFFF.
  - phy_enable is ignored in END.
- Output holding: header fields hold until the next header_valid. crc_error holds until the next packet_done. payload_valid, header_valid, packet_done and phy_reset are pulses.
- WC = 16'hFFFF: the counter is 16-bit and must not wrap early.
- phy_enable held high on every cycle must be handled at full rate.
- Reset mid-packet: immediately back to HEADER with no packet_done and no phy_reset pulse.

Test Plan:
- Short packet, bytes 00 00 00 00 -> header_valid with VC=0, DT=0, WC=0, ecc_error=0; then packet_done=1, phy_reset=1 for one cycle, crc_error=0; no payload_valid.
- Same packet with ECC byte 0x01 -> ecc_error=1; packet still completes with packet_done.
- Long packet DI=0x2A, WC=0x0009, ECC from the bench model; payload "123456789" (31..39); CRC bytes 0x91, 0x6F -> nine payload_valid pulses with bytes 31..39 each one cycle after input; crc_error=0.
- As above but CRC bytes 0x92, 0x6F -> crc_error=1 at packet_done.
- Long DI=0x2A, WC=0, CRC bytes FF FF -> no payload_valid, crc_error=0. phy_enable gapped randomly (1 in 4 cycles) must give identical results.
- Assert reset after the 3rd payload byte, then send a full short packet -> no packet_done for the aborted packet; the new header decodes correctly.
